// File: rtl/pipe_pkg.sv
// Shared constants for the parametrised pipeline-stage register.
// Field indices name the fields carried by the IF/ID instance.
package pipe_pkg;

  localparam int          DATA_W_DEF     = 32;
  localparam int          NUM_FIELDS_DEF = 2;
  localparam logic [31:0] NOP_VALUE_DEF  = 32'h0000_0000;

  localparam int FIELD_IR = 0;
  localparam int FIELD_PC = 1;

  // Where the main slot takes its next contents from.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_SKID = 2'd1,
    SRC_IN   = 2'd2,
    SRC_NOP  = 2'd3
  } m_src_e;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data register. Clear (flush) has priority over load; an
// invalid slot always holds the bubble value so its data is never stale.
module pipe_slot #(
  parameter int           W   = 64,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         Clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Valid/data register, async reset to an empty bubble.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= NOP;
    end else if (clr) begin
      valid <= 1'b0;
      q     <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer (main slot M feeds the downstream, skid slot S absorbs the one
// entry that arrives while M is stalled). in_ready comes straight from
// the skid valid flop, so back-pressure never forms a combinational path.
// Optional build macro: PIPE_STAGE_PERF_EN adds stall_cnt / flush_cnt.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                NUM_FIELDS = NUM_FIELDS_DEF,
  parameter logic [DATA_W-1:0] NOP_VALUE  = DATA_W'(NOP_VALUE_DEF)
) (
  input  logic                         Clk,
  input  logic                         rst_n,
  input  logic                         Flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*NUM_FIELDS-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt,
`endif
  output logic [DATA_W*NUM_FIELDS-1:0] out_data
);

  localparam int           W       = DATA_W * NUM_FIELDS;
  localparam logic [W-1:0] NOP_ALL = {NUM_FIELDS{NOP_VALUE}};

  logic         mv, sv;
  logic [W-1:0] md, sd;
  logic         in_fire, out_fire, m_free;
  m_src_e       m_src;
  logic         m_load, m_clr, s_load, s_clr;
  logic [W-1:0] m_d;

  assign in_ready  = ~sv;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = mv & out_ready;
  assign m_free    = ~mv | out_fire;
  assign out_valid = mv;
  assign out_data  = md;

  // Steering: flush wins; a free M drains S first to keep order, otherwise
  // takes the input; a stalled M parks the incoming entry in S.
  always_comb begin
    m_src  = SRC_HOLD;
    s_load = 1'b0;
    s_clr  = 1'b0;
    if (Flush) begin
      m_src = SRC_NOP;
      s_clr = 1'b1;
    end else if (m_free) begin
      if (sv) begin
        m_src = SRC_SKID;
        if (in_fire) s_load = 1'b1;
        else         s_clr  = 1'b1;
      end else if (in_fire) begin
        m_src = SRC_IN;
      end else begin
        m_src = SRC_NOP;
      end
    end else if (in_fire) begin
      s_load = 1'b1;
    end
  end

  // Decode the M source into slot controls.
  always_comb begin
    m_load = (m_src == SRC_SKID) || (m_src == SRC_IN);
    m_clr  = (m_src == SRC_NOP);
    m_d    = (m_src == SRC_SKID) ? sd : in_data;
  end

  pipe_slot #(.W(W), .NOP(NOP_ALL)) u_main (
    .Clk   (Clk),
    .rst_n (rst_n),
    .clr   (m_clr),
    .load  (m_load),
    .d     (m_d),
    .valid (mv),
    .q     (md)
  );

  pipe_slot #(.W(W), .NOP(NOP_ALL)) u_skid (
    .Clk   (Clk),
    .rst_n (rst_n),
    .clr   (s_clr),
    .load  (s_load),
    .d     (in_data),
    .valid (sv),
    .q     (sd)
  );

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters of stalled cycles and flush cycles.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mv && !out_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (Flush && flush_cnt != 32'hFFFF_FFFF)            flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
